fifo_wr_frontend: RTL and testbench

//  Write-side front end of the dual-clock FIFO; runs entirely in the write clock domain.

---
 rtl/fifo_wr_frontend_if.sv | 29 ++
 rtl/fifo_wr_frontend.sv | 131 +++++++++++++
 tb/tb_fifo_wr_frontend.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_frontend_if.sv
// Write-side bundle of the dual-clock FIFO front end: upstream stream, FIFO full flag,
// RAM write port and packet statistics.
interface fifo_wr_frontend_if #(
    parameter int PTR_WIDTH  = 8,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;
    logic                  oflow;
    logic                  data_wr;
    logic                  mem_we;
    logic [PTR_WIDTH-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [CNT_WIDTH-1:0]  pkt_count;
    logic [CNT_WIDTH-1:0]  drop_count;

    modport master (
        output s_valid, s_data, s_last, oflow,
        input  s_ready, data_wr, mem_we, mem_addr, mem_wdata, pkt_count, drop_count
    );

    modport slave (
        input  s_valid, s_data, s_last, oflow,
        output s_ready, data_wr, mem_we, mem_addr, mem_wdata, pkt_count, drop_count
    );
endinterface

// File: rtl/fifo_wr_frontend.sv
// Write-clock-domain front end of the dual-clock FIFO: 2-entry skid buffer feeding the RAM
// write port, with optional truncation of packets that hit a full FIFO.
module fifo_wr_frontend #(
    parameter int PTR_WIDTH    = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int CNT_WIDTH    = 16,
    parameter int DROP_ON_FULL = 0
) (
    input logic              aclk,
    input logic              aresetn,
    fifo_wr_frontend_if.slave bus
);

    typedef enum logic [1:0] {
        ST_SOP  = 2'd0,
        ST_MID  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_count;
    logic [1:0]            w_count_nxt;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [PTR_WIDTH-1:0]  r_wr_addr;
    logic                  r_s_ready;
    logic [CNT_WIDTH-1:0]  r_pkt_cnt;
    logic [CNT_WIDTH-1:0]  r_drop_cnt;

    logic w_push;
    logic w_pop;
    logic w_full_discard;
    logic w_discard;
    logic w_keep;
    logic w_pkt_inc;
    logic w_drop_inc;
    logic w_to_tail;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    assign w_push = bus.s_valid & r_s_ready;
    assign w_pop  = (r_count != 2'd0) & ~bus.oflow;

    // Only reachable in truncation mode: in back-pressure mode s_ready is low whenever count==2.
    assign w_full_discard = (DROP_ON_FULL != 0) && (r_count == 2'd2) && !w_pop;

    always_comb begin
        w_state_nxt = r_state;
        w_discard   = 1'b0;
        w_pkt_inc   = 1'b0;
        w_drop_inc  = 1'b0;
        case (r_state)
            ST_SOP, ST_MID: begin
                if (w_push) begin
                    if (w_full_discard) begin
                        w_discard   = 1'b1;
                        w_drop_inc  = 1'b1;
                        w_state_nxt = bus.s_last ? ST_SOP : ST_DROP;
                    end else begin
                        w_pkt_inc   = bus.s_last;
                        w_state_nxt = bus.s_last ? ST_SOP : ST_MID;
                    end
                end
            end
            ST_DROP: begin
                if (w_push) begin
                    w_discard = 1'b1;
                    if (bus.s_last) begin
                        w_state_nxt = ST_SOP;
                    end
                end
            end
            default: w_state_nxt = ST_SOP;
        endcase
    end

    assign w_keep      = w_push & ~w_discard;
    assign w_count_nxt = r_count + {1'b0, w_keep} - {1'b0, w_pop};
    // A kept beat lands behind whatever survives this cycle's pop.
    assign w_to_tail   = (r_count == 2'd1) ? ~w_pop : (r_count == 2'd2);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= ST_SOP;
            r_count    <= 2'd0;
            r_wr_addr  <= '0;
            r_s_ready  <= 1'b0;
            r_pkt_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_s_ready <= (DROP_ON_FULL != 0) ? 1'b1 : (w_count_nxt <= 2'd1);
            if (w_pop) begin
                r_wr_addr <= r_wr_addr + {{(PTR_WIDTH-1){1'b0}}, 1'b1};
            end
            if (w_pkt_inc) begin
                r_pkt_cnt <= sat_inc(r_pkt_cnt);
            end
            if (w_drop_inc) begin
                r_drop_cnt <= sat_inc(r_drop_cnt);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_pop) begin
            r_head <= r_tail;
        end
        if (w_keep) begin
            if (w_to_tail) begin
                r_tail <= bus.s_data;
            end else begin
                r_head <= bus.s_data;
            end
        end
    end

    assign bus.s_ready    = r_s_ready;
    assign bus.mem_we     = w_pop;
    assign bus.data_wr    = w_pop;
    assign bus.mem_addr   = r_wr_addr;
    // Gated so the unreset data registers never reach the RAM bus during reset.
    assign bus.mem_wdata  = w_pop ? r_head : '0;
    assign bus.pkt_count  = r_pkt_cnt;
    assign bus.drop_count = r_drop_cnt;

endmodule

// File: tb/tb_fifo_wr_frontend.sv
// Directed bench: back-pressure instance (PTR_WIDTH=3) and truncating instance (CNT_WIDTH=2).
module tb_fifo_wr_frontend;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_frontend_if #(.PTR_WIDTH(3), .DATA_WIDTH(32), .CNT_WIDTH(16)) ifa ();
    fifo_wr_frontend_if #(.PTR_WIDTH(8), .DATA_WIDTH(32), .CNT_WIDTH(2))  ifb ();

    fifo_wr_frontend #(.PTR_WIDTH(3), .DATA_WIDTH(32), .CNT_WIDTH(16), .DROP_ON_FULL(0)) u_a (
        .aclk(clk), .aresetn(rst_n), .bus(ifa.slave)
    );
    fifo_wr_frontend #(.PTR_WIDTH(8), .DATA_WIDTH(32), .CNT_WIDTH(2), .DROP_ON_FULL(1)) u_b (
        .aclk(clk), .aresetn(rst_n), .bus(ifb.slave)
    );

    int checks = 0;
    int errors = 0;
    int idx;
    int wcnt;
    logic rdy_seen;
    int t4_addr [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    logic [31:0] exp_b [5] = '{32'hD0, 32'hD1, 32'hE0, 32'hE1, 32'hE2};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        ifa.s_valid = 1'b0; ifa.s_data = '0; ifa.s_last = 1'b0; ifa.oflow = 1'b0;
        ifb.s_valid = 1'b0; ifb.s_data = '0; ifb.s_last = 1'b0; ifb.oflow = 1'b0;

        // Reset state
        @(negedge clk); #1;
        chk("rst_a_ready", 64'(ifa.s_ready), 64'd0);
        chk("rst_a_we", 64'(ifa.mem_we), 64'd0);
        chk("rst_a_wdata", 64'(ifa.mem_wdata), 64'd0);
        chk("rst_a_pkt", 64'(ifa.pkt_count), 64'd0);
        chk("rst_b_ready", 64'(ifb.s_ready), 64'd0);
        chk("rst_b_drop", 64'(ifb.drop_count), 64'd0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("rel_a_ready_still_low", 64'(ifa.s_ready), 64'd0);
        @(negedge clk); #1;
        chk("rel_a_ready", 64'(ifa.s_ready), 64'd1);
        chk("rel_b_ready", 64'(ifb.s_ready), 64'd1);
        chk("rel_a_we", 64'(ifa.mem_we), 64'd0);

        // Three-beat packet, no overflow
        ifa.s_valid = 1'b1; ifa.s_data = 32'hA1; ifa.s_last = 1'b0;
        @(negedge clk); ifa.s_data = 32'hA2; #1;
        chk("t2_we0", 64'(ifa.mem_we), 64'd1);
        chk("t2_wr0", 64'(ifa.data_wr), 64'd1);
        chk("t2_addr0", 64'(ifa.mem_addr), 64'd0);
        chk("t2_data0", 64'(ifa.mem_wdata), 64'hA1);
        @(negedge clk); ifa.s_data = 32'hA3; ifa.s_last = 1'b1; #1;
        chk("t2_we1", 64'(ifa.mem_we), 64'd1);
        chk("t2_addr1", 64'(ifa.mem_addr), 64'd1);
        chk("t2_data1", 64'(ifa.mem_wdata), 64'hA2);
        @(negedge clk); ifa.s_valid = 1'b0; ifa.s_last = 1'b0; #1;
        chk("t2_we2", 64'(ifa.mem_we), 64'd1);
        chk("t2_addr2", 64'(ifa.mem_addr), 64'd2);
        chk("t2_data2", 64'(ifa.mem_wdata), 64'hA3);
        @(negedge clk); #1;
        chk("t2_idle_we", 64'(ifa.mem_we), 64'd0);
        chk("t2_pkt", 64'(ifa.pkt_count), 64'd1);

        // Continuous stream with oflow held for 10 cycles
        idx = 0; wcnt = 0; rdy_seen = ifa.s_ready;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ifa.s_valid && rdy_seen) idx++;
            ifa.oflow   = (c < 10);
            ifa.s_valid = (idx < 6);
            ifa.s_data  = 32'hB0 + idx;
            ifa.s_last  = (idx == 5);
            #1;
            rdy_seen = ifa.s_ready;
            if (c < 10) chk("t3_no_write_in_oflow", 64'(ifa.mem_we), 64'd0);
            if (c == 2 || c == 9) chk("t3_ready_low", 64'(ifa.s_ready), 64'd0);
            if (ifa.mem_we) begin
                chk("t3_data", 64'(ifa.mem_wdata), 64'(32'hB0 + wcnt));
                chk("t3_addr", 64'(ifa.mem_addr), 64'((3 + wcnt) % 8));
                wcnt++;
            end
        end
        ifa.s_valid = 1'b0; ifa.s_last = 1'b0; ifa.oflow = 1'b0;
        chk("t3_write_count", 64'(wcnt), 64'd6);
        chk("t3_pkt", 64'(ifa.pkt_count), 64'd2);

        // Reset asserted while the skid holds two beats
        @(negedge clk); ifa.oflow = 1'b1; ifa.s_valid = 1'b1; ifa.s_data = 32'hF0;
        @(negedge clk); ifa.s_data = 32'hF1;
        @(negedge clk); ifa.s_valid = 1'b0; #1;
        chk("mid_full_ready", 64'(ifa.s_ready), 64'd0);
        @(negedge clk); rst_n = 1'b0; ifa.oflow = 1'b0; #1;
        chk("mid_rst_ready", 64'(ifa.s_ready), 64'd0);
        chk("mid_rst_we", 64'(ifa.mem_we), 64'd0);
        chk("mid_rst_wr", 64'(ifa.data_wr), 64'd0);
        chk("mid_rst_wdata", 64'(ifa.mem_wdata), 64'd0);
        chk("mid_rst_addr", 64'(ifa.mem_addr), 64'd0);
        chk("mid_rst_pkt", 64'(ifa.pkt_count), 64'd0);
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("mid_rel_ready_low", 64'(ifa.s_ready), 64'd0);
        @(negedge clk); #1;
        chk("mid_rel_ready", 64'(ifa.s_ready), 64'd1);
        chk("mid_rel_we", 64'(ifa.mem_we), 64'd0);

        // Ten single-beat packets through a 3-bit address
        idx = 0; wcnt = 0; rdy_seen = ifa.s_ready;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ifa.s_valid && rdy_seen) idx++;
            ifa.s_valid = (idx < 10);
            ifa.s_data  = 32'hC0 + idx;
            ifa.s_last  = 1'b1;
            #1;
            rdy_seen = ifa.s_ready;
            if (ifa.mem_we && wcnt < 10) begin
                chk("t4_addr", 64'(ifa.mem_addr), 64'(t4_addr[wcnt]));
                chk("t4_data", 64'(ifa.mem_wdata), 64'(32'hC0 + wcnt));
                wcnt++;
            end
        end
        ifa.s_valid = 1'b0; ifa.s_last = 1'b0;
        chk("t4_write_count", 64'(wcnt), 64'd10);
        chk("t4_pkt", 64'(ifa.pkt_count), 64'd10);

        // Truncating mode: overflow during a 5-beat packet, then a clean packet
        idx = 0; wcnt = 0; rdy_seen = ifb.s_ready;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ifb.s_valid && rdy_seen) idx++;
            ifb.oflow   = (c < 4);
            ifb.s_valid = (idx < 8);
            ifb.s_data  = (idx < 5) ? 32'hD0 + idx : 32'hE0 + (idx - 5);
            ifb.s_last  = (idx == 4) || (idx == 7);
            #1;
            rdy_seen = ifb.s_ready;
            if (c < 4) chk("t5_no_write_in_oflow", 64'(ifb.mem_we), 64'd0);
            if (ifb.mem_we) begin
                if (wcnt < 5) begin
                    chk("t5_data", 64'(ifb.mem_wdata), 64'(exp_b[wcnt]));
                    chk("t5_addr", 64'(ifb.mem_addr), 64'(wcnt));
                end
                wcnt++;
            end
        end
        ifb.s_valid = 1'b0; ifb.s_last = 1'b0; ifb.oflow = 1'b0;
        chk("t5_write_count", 64'(wcnt), 64'd5);
        chk("t5_drop", 64'(ifb.drop_count), 64'd1);
        chk("t5_pkt", 64'(ifb.pkt_count), 64'd1);

        @(negedge clk); rst_n = 1'b0; #1;
        chk("t6_rst_drop", 64'(ifb.drop_count), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // Packet counter saturation
        idx = 0; rdy_seen = ifb.s_ready;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ifb.s_valid && rdy_seen) idx++;
            ifb.s_valid = (idx < 5);
            ifb.s_data  = 32'(idx);
            ifb.s_last  = 1'b1;
            #1;
            rdy_seen = ifb.s_ready;
            if (c == 2) chk("t6_pkt_mid", 64'(ifb.pkt_count), 64'd2);
        end
        ifb.s_valid = 1'b0;
        chk("t6_pkt_sat", 64'(ifb.pkt_count), 64'd3);

        // Drop counter saturation: five 3-beat packets with oflow held
        idx = 0; rdy_seen = ifb.s_ready;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ifb.s_valid && rdy_seen) idx++;
            ifb.oflow   = 1'b1;
            ifb.s_valid = (idx < 15);
            ifb.s_data  = 32'(idx);
            ifb.s_last  = (idx % 3 == 2);
            #1;
            rdy_seen = ifb.s_ready;
            if (c == 5) chk("t6_drop_mid", 64'(ifb.drop_count), 64'd2);
        end
        ifb.s_valid = 1'b0; ifb.s_last = 1'b0;
        chk("t6_drop_sat", 64'(ifb.drop_count), 64'd3);
        chk("t6_pkt_hold", 64'(ifb.pkt_count), 64'd3);
        chk("t6_no_write", 64'(ifb.mem_we), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
